// File: rtl/sram_controller_param.sv
// Asynchronous single-port SRAM controller for the MEM stage data window.
// Fixed-length read/write cycles with programmable wait states.
module sram_controller_param #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SRAM_AW     = 17,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               write_en,
    input  logic               read_en,
    input  logic [31:0]        address,
    input  logic [DATA_W-1:0]  writeData,
    output logic [DATA_W-1:0]  readData,
    output logic               ready,
    output logic               err,
    inout  wire  [DATA_W-1:0]  SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N
);

    localparam int unsigned BYTE_SH = $clog2(DATA_W / 8);
    localparam int unsigned CNT_W   = $clog2(WAIT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_wr_q;
    logic               oor_q;
    logic [SRAM_AW-1:0] addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;

    logic [32:0] diff;
    logic [31:0] idx;
    logic        in_range;
    logic        req;
    logic        accept;
    logic        rd_cap;
    logic        dq_oe;

    // 33-bit subtract: bit 32 flags an address below the window
    assign diff     = {1'b0, address} - {1'b0, BASE_ADDR};
    assign idx      = diff[31:0] >> BYTE_SH;
    assign in_range = !diff[32] && ((idx >> SRAM_AW) == 32'd0);
    assign req      = read_en | write_en;
    assign accept   = (state_q == S_IDLE) && req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (!in_range)
                        state_d = S_DONE;
                    else if (read_en)
                        state_d = S_RD;
                    else
                        state_d = S_WR;
                end
            end
            S_RD, S_WR: begin
                state_d = S_WAIT;
                cnt_d   = CNT_W'(WAIT_CYCLES - 1);
            end
            S_WAIT: begin
                if (cnt_q != '0)
                    cnt_d = cnt_q - 1'b1;
                else
                    state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_cap = (state_q == S_WAIT) && (cnt_q == '0) && !is_wr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            oor_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                oor_q   <= !in_range;
                is_wr_q <= in_range && !read_en;
            end
            if (accept && in_range) begin
                addr_q  <= idx[SRAM_AW-1:0];
                wdata_q <= writeData;
            end
            if (rd_cap)
                rdata_q <= SRAM_DQ;
        end
    end

    // Write data stays on the bus through DONE for hold after WE_N rises
    assign dq_oe = is_wr_q && ((state_q == S_WR) ||
                               (state_q == S_WAIT) ||
                               (state_q == S_DONE));

    assign SRAM_DQ   = dq_oe ? wdata_q : 'z;
    assign SRAM_ADDR = addr_q;
    assign SRAM_CE_N = !((state_q == S_RD) || (state_q == S_WR) ||
                         (state_q == S_WAIT));
    assign SRAM_OE_N = !((state_q == S_RD) ||
                         ((state_q == S_WAIT) && !is_wr_q));
    assign SRAM_WE_N = !((state_q == S_WR) ||
                         ((state_q == S_WAIT) && is_wr_q));

    assign readData = rdata_q;
    assign ready    = (state_q == S_DONE) || ((state_q == S_IDLE) && !req);
    assign err      = (state_q == S_DONE) && oor_q;

endmodule

// File: tb/tb_sram_controller_param.sv
// Directed bench for sram_controller_param with a behavioural SRAM model.
// Covers access timing, strobes, range errors, wait variants and reset.
module tb_sram_controller_param;

    localparam int SAW = 17;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        write_en = 1'b0;
    logic        read_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] writeData = '0;
    logic [31:0] readData;
    logic        ready;
    logic        err;
    wire  [31:0] dq;
    logic [SAW-1:0] sram_addr;
    logic        we_n, oe_n, ce_n;

    logic        read_en_p = 1'b0;
    logic [31:0] rd1, rd8;
    logic        ready1, ready8, err1, err8;
    wire  [31:0] dq1, dq8;
    logic [SAW-1:0] sa1, sa8;
    logic        we1, oe1, ce1, we8, oe8, ce8;

    logic [31:0] mem [0:63];

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    sram_controller_param #(.WAIT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .write_en(write_en), .read_en(read_en),
        .address(address), .writeData(writeData), .readData(readData),
        .ready(ready), .err(err), .SRAM_DQ(dq), .SRAM_ADDR(sram_addr),
        .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n)
    );

    sram_controller_param #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .write_en(1'b0), .read_en(read_en_p),
        .address(32'h400), .writeData(32'h0), .readData(rd1),
        .ready(ready1), .err(err1), .SRAM_DQ(dq1), .SRAM_ADDR(sa1),
        .SRAM_WE_N(we1), .SRAM_OE_N(oe1), .SRAM_CE_N(ce1)
    );

    sram_controller_param #(.WAIT_CYCLES(8)) dut8 (
        .clk(clk), .rst(rst), .write_en(1'b0), .read_en(read_en_p),
        .address(32'h400), .writeData(32'h0), .readData(rd8),
        .ready(ready8), .err(err8), .SRAM_DQ(dq8), .SRAM_ADDR(sa8),
        .SRAM_WE_N(we8), .SRAM_OE_N(oe8), .SRAM_CE_N(ce8)
    );

    pullup (dq);
    pullup (dq1);
    pullup (dq8);

    // SRAM model: writes while WE_N/CE_N low, drives reads while OE_N/CE_N low
    assign dq = (!ce_n && !oe_n) ? mem[sram_addr[5:0]] : 'z;

    always @(posedge clk)
        if (!we_n && !ce_n)
            mem[sram_addr[5:0]] <= dq;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic access(input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          output int done,
                          output logic [31:0] errm, output logic [31:0] wem,
                          output logic [31:0] oem, output logic [31:0] cem,
                          output logic [31:0] dqm,
                          output logic [SAW-1:0] adr1);
        done = -1;
        errm = '0; wem = '0; oem = '0; cem = '0; dqm = '0;
        adr1 = '0;
        read_en = rd;
        write_en = wr;
        address = a;
        writeData = d;
        #1;
        for (int c = 0; c < 24; c++) begin
            errm[c] = err;
            wem[c] = !we_n;
            oem[c] = !oe_n;
            cem[c] = !ce_n;
            dqm[c] = (dq === d);
            if (c == 1) adr1 = sram_addr;
            if (done >= 0) break;
            if (ready && c > 0) begin
                done = c;
                read_en = 1'b0;
                write_en = 1'b0;
            end
            @(posedge clk); #1;
            if (c == 0) begin
                address = a ^ 32'h0000_0010;
                writeData = ~d;
            end
        end
        read_en = 1'b0;
        write_en = 1'b0;
    endtask

    int done;
    logic [31:0] errm, wem, oem, cem, dqm;
    logic [SAW-1:0] adr1;
    int r1[$];
    int r8[$];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        #12;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_rdata", readData, 32'h0);
        check("rst_strobes", {29'b0, we_n, oe_n, ce_n}, 32'h7);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_dq_z", dq, 32'hFFFF_FFFF);
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", {31'b0, ready}, 32'd1);
        check("idle_addr", {15'b0, sram_addr}, 32'h0);

        access(1'b0, 1'b1, 32'h400, 32'hDEAD_BEEF,
               done, errm, wem, oem, cem, dqm, adr1);
        check("wr_done", done, 32'd6);
        check("wr_addr", {15'b0, adr1}, 32'h0);
        check("wr_we_mask", wem, 32'h3E);
        check("wr_dq_mask", dqm, 32'h7E);
        check("wr_oe_mask", oem, 32'h0);
        check("wr_ce_mask", cem, 32'h3E);
        check("wr_err", errm, 32'h0);

        access(1'b1, 1'b0, 32'h400, 32'h0,
               done, errm, wem, oem, cem, dqm, adr1);
        check("rd_done", done, 32'd6);
        check("rd_addr", {15'b0, adr1}, 32'h0);
        check("rd_oe_mask", oem, 32'h3E);
        check("rd_we_mask", wem, 32'h0);
        check("rd_data", readData, 32'hDEAD_BEEF);

        access(1'b1, 1'b0, 32'h3FC, 32'h0,
               done, errm, wem, oem, cem, dqm, adr1);
        check("oor_lo_done", done, 32'd1);
        check("oor_lo_err", errm, 32'h2);
        check("oor_lo_ce", cem, 32'h0);
        check("oor_lo_oe", oem, 32'h0);
        check("oor_lo_rdata", readData, 32'hDEAD_BEEF);

        access(1'b0, 1'b1, 32'h400 + 32'h8_0000, 32'h1234_5678,
               done, errm, wem, oem, cem, dqm, adr1);
        check("oor_hi_done", done, 32'd1);
        check("oor_hi_err", errm, 32'h2);
        check("oor_hi_we", wem, 32'h0);
        check("oor_hi_dq", dqm, 32'h0);
        check("oor_hi_rdata", readData, 32'hDEAD_BEEF);

        access(1'b1, 1'b1, 32'h404, 32'h0,
               done, errm, wem, oem, cem, dqm, adr1);
        check("both_done", done, 32'd6);
        check("both_oe", oem, 32'h3E);
        check("both_we", wem, 32'h0);
        check("both_addr", {15'b0, adr1}, 32'h1);
        check("both_rdata", readData, 32'h0);

        access(1'b0, 1'b1, 32'h400 + 32'h8_0000 - 32'h4, 32'h5555_AAAA,
               done, errm, wem, oem, cem, dqm, adr1);
        check("last_done", done, 32'd6);
        check("last_addr", {15'b0, adr1}, 32'h1_FFFF);
        check("last_err", errm, 32'h0);

        access(1'b0, 1'b1, 32'h408, 32'h1111_1111,
               done, errm, wem, oem, cem, dqm, adr1);
        access(1'b0, 1'b1, 32'h40D, 32'h2222_2222,
               done, errm, wem, oem, cem, dqm, adr1);
        check("off_addr", {15'b0, adr1}, 32'h3);

        read_en_p = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (ready1 && c > 0) r1.push_back(c);
            if (ready8 && c > 0) r8.push_back(c);
            @(posedge clk); #1;
        end
        read_en_p = 1'b0;
        check("w1_first", (r1.size() > 0) ? r1[0] : -1, 32'd3);
        check("w1_space", (r1.size() > 1) ? r1[1] - r1[0] : -1, 32'd4);
        check("w8_first", (r8.size() > 0) ? r8[0] : -1, 32'd10);
        check("w8_space", (r8.size() > 1) ? r8[1] - r8[0] : -1, 32'd11);
        repeat (12) @(posedge clk);
        #1;

        write_en = 1'b1;
        address = 32'h408;
        writeData = 32'hCAFE_F00D;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_we", {31'b0, we_n}, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_we", {31'b0, we_n}, 32'd1);
        check("mid_rst_ce", {31'b0, ce_n}, 32'd1);
        check("mid_rst_dq", dq, 32'hFFFF_FFFF);
        check("mid_rst_rdata", readData, 32'h0);
        check("mid_rst_addr", {15'b0, sram_addr}, 32'h0);
        write_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        access(1'b1, 1'b0, 32'h40C, 32'h0,
               done, errm, wem, oem, cem, dqm, adr1);
        check("post_rst_done", done, 32'd6);
        check("post_rst_rdata", readData, 32'h2222_2222);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sram_controller_param.md
# sram_controller_param

Parametrised single-port asynchronous-SRAM controller sitting between the MEM stage and the external SRAM. Translates a byte address in the data window into a word address and runs a fixed-length read or write cycle with a programmable wait count. Holds the pipeline through `ready` until the cycle completes. Adds chip/output-enable control, registered read data and an out-of-range error flag.

## Interface
- `DATA_W`, 32: SRAM data width in bits; must be a power of two, at least 8.
- `SRAM_AW`, 17: SRAM word-address width.
- `BASE_ADDR`, 1024: first byte address of the data window.
- `WAIT_CYCLES`, 4: wait-state cycles per access; must be 1 or more.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `write_en` in 1: write request, held until `ready`.
- `read_en` in 1: read request, held until `ready`; has priority over `write_en`.
- `address` in 32: byte address.
- `writeData` in DATA_W: write data.
- `readData` out DATA_W: registered read data.
- `ready` out 1: access complete, or no access pending.
- `err` out 1: one-cycle pulse for an out-of-range request.
- `SRAM_DQ` inout DATA_W: SRAM data bus.
- `SRAM_ADDR` out SRAM_AW: registered word address.
- `SRAM_WE_N`, `SRAM_OE_N`, `SRAM_CE_N` out 1 each: active-low strobes.

## Operation
- Word index: `idx = (address - BASE_ADDR) >> log2(DATA_W/8)`.
  - Low byte-offset bits are ignored.
- In range means `address >= BASE_ADDR` and `idx < 2**SRAM_AW`.
- Subtraction is done at 33 bits so an underflow is detected rather than wrapping.
- States: IDLE, RD, WR, WAIT, DONE.
  - IDLE → RD if `read_en`.
  - IDLE → WR if `write_en` and not `read_en`.
  - Stay in IDLE otherwise.
  - Out-of-range request: IDLE → DONE directly. No strobes, `err`=1 in DONE, `readData` unchanged.
  - RD/WR → WAIT. The wait counter loads `WAIT_CYCLES-1`.
  - WAIT stays while counter ≠ 0 and decrements each cycle.
  - WAIT → DONE when counter = 0.
  - DONE → IDLE unconditionally.
- On the IDLE→RD/WR edge, capture three things: `SRAM_ADDR` ← `idx[SRAM_AW-1:0]`, the write data, and the operation type.
- Strobes:
  - `SRAM_CE_N` is low in RD, WR and WAIT.
  - `SRAM_OE_N` is low in RD and in WAIT of a read.
  - `SRAM_WE_N` is low in WR and in WAIT of a write. It is high in DONE.
- `SRAM_DQ` is driven with the latched write data in WR, WAIT-of-write and DONE-of-write, giving one cycle of data hold after `SRAM_WE_N` rises. It is high-Z at all other times.
- `readData` loads from `SRAM_DQ` on the clock edge that leaves WAIT during a read. It holds its value until the next read capture.
- `ready` is combinational:
  - 1 in DONE.
  - 1 in IDLE when `read_en` = `write_en` = 0.
  - 0 otherwise.
- Enables that are still high in the cycle after DONE start a new access. This is correct behaviour for back-to-back requests.

## Timing
- Reset values: state IDLE, `SRAM_ADDR`=0, `readData`=0, `err`=0, `SRAM_WE_N`=`SRAM_OE_N`=`SRAM_CE_N`=1, `SRAM_DQ` high-Z, counter 0.
  - `ready` then follows its IDLE rule.
- Latency: request present in IDLE at cycle 0 → RD/WR at cycle 1 → WAIT at cycles 2..WAIT_CYCLES+1 → DONE (`ready`=1) at cycle WAIT_CYCLES+2.
  - Default access time is 6 cycles.
- Out-of-range request: DONE at cycle 1, with `ready`=1 and `err`=1 for that one cycle.
- Changes to `address` or `writeData` after cycle 0 have no effect on the access in flight.
- Reset asserted mid-access: immediately and asynchronously return to the reset values.
  - Strobes go high and `SRAM_DQ` is released in the same cycle.
  - A partial write is allowed to corrupt the addressed word; no other word is touched.
- Boundary addresses: `BASE_ADDR` maps to `SRAM_ADDR`=0. `BASE_ADDR + (2**SRAM_AW)*DATA_W/8 - 4` (the last word) is valid. One word beyond that is out of range.

## Test plan
- Write 0xDEADBEEF to address 0x400, then read 0x400.
  - Both accesses: `SRAM_ADDR`=0, `ready` high exactly at cycle 6.
  - After the read DONE, `readData`=0xDEADBEEF.
  - During the write, `SRAM_WE_N` is low for cycles 1–5 and DQ is driven for cycles 1–6.
- `read_en`=`write_en`=1 at address 0x404.
  - A read is performed: `SRAM_OE_N` low, `SRAM_WE_N` stays 1, `SRAM_ADDR`=1.
- Read address 0x3FC, then write address 0x400 + 2^17·4.
  - Each produces `ready`=`err`=1 at cycle 1.
  - No strobe toggles; `readData` is unchanged.
- Rebuild with `WAIT_CYCLES`=1 and `WAIT_CYCLES`=8.
  - `ready` arrives at cycle 3 and cycle 10 respectively.
  - Back-to-back reads with the enables held give DONE spaced 4 and 11 cycles apart.
- Assert `rst`=0 during the WAIT of a write.
  - Same cycle: `SRAM_WE_N`=`SRAM_CE_N`=1 and DQ is high-Z.
  - After release, an IDLE-state read of another address returns its previously written value.
